button_conditioner: RTL and testbench

- Parametrised, multi-channel successor to the single-button debouncer.
- Per channel: two-flop synchroniser, stability-count debounce, one-cycle rise/fall strobes and an optional auto-repeat "press" strobe for held buttons.
- Sits between the raw front-panel buttons/switches and the equaliser UI control logic. Menu/gain stepping consumes `press`, so holding a button steps a value repeatedly.

---
 rtl/peq_ui_pkg.sv | 21 ++
 rtl/button_channel.sv | 146 ++++++++++++++
 rtl/button_conditioner.sv | 49 ++++
 tb/tb_button_conditioner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/peq_ui_pkg.sv
// rtl/peq_ui_pkg.sv - shared definitions for the front-panel button conditioner
// Contents: auto-repeat FSM state encoding, 27 MHz timing constants used as
// parameter defaults, and a small integer max helper for width calculations.
package peq_ui_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  localparam int CLK_HZ        = 27000000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int HOLD_500MS    = CLK_HZ / 2;
  localparam int REPEAT_100MS  = CLK_HZ / 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, debounce, edge strobes, auto-repeat
// Ports:
//   clock   in   system clock
//   reset_n in   asynchronous active-low reset
//   noisy   in   raw asynchronous button level (1 = pressed)
//   clean   out  debounced level
//   rise    out  one-cycle strobe when clean first reads 1
//   fall    out  one-cycle strobe when clean first reads 0
//   press   out  one-cycle strobe on press and on each auto-repeat
module button_channel
  import peq_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("button_channel: cycle parameters must be >= 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          s;
  logic          cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  assign s = sync_q[1];

  // Any disagreement between s and the candidate restarts the stability count;
  // the count saturates at DEBOUNCE_CYCLES so a long hold never wraps.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (s != cand_q) begin
      cand_d = s;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_d = clean_d & ~clean_q;
  assign fall_d = ~clean_d & clean_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], noisy};
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

  if (REPEAT_EN) begin : g_repeat
    localparam int TW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    rep_state_e    state_q;
    logic [TW-1:0] timer_q;
    logic          press_q;

    // Release is checked first so a fall coinciding with a timer expiry
    // returns to IDLE without a repeat strobe.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        timer_q <= '0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (fall_d) begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (rise_d) begin
                state_q <= ST_HOLD;
                timer_q <= '0;
                press_q <= 1'b1;
              end
            end
            ST_HOLD: begin
              if (timer_q == HOLD_LAST) begin
                state_q <= ST_REPEAT;
                timer_q <= '0;
                press_q <= 1'b1;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (timer_q == REP_LAST) begin
                timer_q <= '0;
                press_q <= 1'b1;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end
          endcase
        end
      end
    end

    assign press = press_q;
  end else begin : g_no_repeat
    assign press = rise_q;
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - NUM_CH independent debounced buttons with auto-repeat
// Ports:
//   clock   in   system clock
//   reset_n in   asynchronous active-low reset
//   noisy   in   [NUM_CH] raw asynchronous button levels (1 = pressed)
//   clean   out  [NUM_CH] debounced levels
//   rise    out  [NUM_CH] one-cycle strobes when clean first reads 1
//   fall    out  [NUM_CH] one-cycle strobes when clean first reads 0
//   press   out  [NUM_CH] one-cycle strobes on press and each auto-repeat
module button_conditioner
  import peq_ui_pkg::*;
#(
  parameter int NUM_CH          = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] noisy,
  output logic [NUM_CH-1:0] clean,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] press
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("button_conditioner: NUM_CH must be >= 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_channel (
      .clock   (clock),
      .reset_n (reset_n),
      .noisy   (noisy[i]),
      .clean   (clean[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .press   (press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

  localparam int NUM_CH = 4;
  localparam int DEB    = 4;
  localparam int HOLD   = 10;
  localparam int REP    = 5;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] noisy   = '0;
  logic [NUM_CH-1:0] clean, rise, fall, press;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: a synchronised sample becomes the clean level once it has
  // been seen for DEB+2 consecutive edges; press fires on the rise cycle and
  // then at HOLD, HOLD+REP, HOLD+2*REP ... cycles after it while clean is high.
  logic [NUM_CH-1:0] m_d1, m_s, m_clean, m_rise, m_fall, m_press;
  int m_run [NUM_CH];
  int m_t0  [NUM_CH];

  button_conditioner #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_EN       (1'b1),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .noisy   (noisy),
    .clean   (clean),
    .rise    (rise),
    .fall    (fall),
    .press   (press)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_d1 = '0; m_s = '0; m_clean = '0;
    m_rise = '0; m_fall = '0; m_press = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = DEB + 2;
      m_t0[c]  = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      logic prev, new_s;
      int   el;
      prev = m_clean[c];
      if (m_run[c] >= DEB + 2) m_clean[c] = m_s[c];
      new_s   = m_d1[c];
      m_d1[c] = noisy[c];
      if (new_s == m_s[c]) begin
        if (m_run[c] < DEB + 2) m_run[c] = m_run[c] + 1;
      end else begin
        m_run[c] = 1;
      end
      m_s[c]    = new_s;
      m_rise[c] = m_clean[c] & ~prev;
      m_fall[c] = ~m_clean[c] & prev;
      if (m_rise[c]) m_t0[c] = cyc;
      el = cyc - m_t0[c];
      m_press[c] = m_clean[c] && (el == 0 || (el >= HOLD && (el - HOLD) % REP == 0));
    end
  endfunction

  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%b expected=%b cycle=%0d", tag, c, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NUM_CH; c++) begin
      chk("clean", c, clean[c], m_clean[c]);
      chk("rise",  c, rise[c],  m_rise[c]);
      chk("fall",  c, fall[c],  m_fall[c]);
      chk("press", c, press[c], m_press[c]);
    end
  endtask

  task automatic step(input logic [NUM_CH-1:0] v);
    noisy = v;
    @(posedge clock);
    cyc++;
    if (reset_n) model_edge();
    #1;
    check_all();
  endtask

  // Step with v held until clean[ch] goes high; returns edges taken (bounded).
  task automatic edges_to_clean(input logic [NUM_CH-1:0] v, input int ch, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step(v);
      if (clean[ch] === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int rises;
    logic [NUM_CH-1:0] v;

    // Reset state
    model_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) step('0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step('0);

    // Clean press on ch0, then hold for repeats and release
    edges_to_clean(4'b0001, 0, n);
    tests++;
    assert (n == DEB + 4) else begin
      fails++;
      $error("FAIL latency_ch0 observed=%0d expected=%0d", n, DEB + 4);
    end
    for (int k = 0; k < 40 - n; k++) step(4'b0001);
    for (int k = 0; k < 15; k++) step('0);

    // Bounce on ch1, then a stable hold
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      step((k % 4) < 2 ? 4'b0010 : 4'b0000);
      if (rise[1]) rises++;
    end
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step(4'b0010);
      if (rise[1]) rises++;
      if (clean[1] === 1'b1 && n == 0) n = k;
    end
    tests++;
    assert (n == DEB + 4) else begin
      fails++;
      $error("FAIL latency_bounce observed=%0d expected=%0d", n, DEB + 4);
    end
    tests++;
    assert (rises == 1) else begin
      fails++;
      $error("FAIL rise_count_bounce observed=%0d expected=1", rises);
    end
    for (int k = 0; k < 15; k++) step('0);

    // Short glitch on ch2
    for (int k = 0; k < 3; k++) step(4'b0100);
    for (int k = 0; k < 15; k++) step('0);

    // Simultaneous ch2/ch3, ch2 released during HOLD
    edges_to_clean(4'b1100, 2, n);
    for (int k = 0; k < 4; k++) step(4'b1100);
    for (int k = 0; k < 30; k++) step(4'b1000);
    for (int k = 0; k < 15; k++) step('0);

    // Reset while ch0 is repeating
    for (int k = 0; k < 25; k++) step(4'b0001);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int k = 0; k < 3; k++) step(4'b0001);
    reset_n = 1'b1;
    edges_to_clean(4'b0001, 0, n);
    tests++;
    assert (n == DEB + 4) else begin
      fails++;
      $error("FAIL latency_after_reset observed=%0d expected=%0d", n, DEB + 4);
    end
    for (int k = 0; k < 10; k++) step(4'b0001);
    for (int k = 0; k < 15; k++) step('0);

    // Randomised levels with mixed short bounces and long holds
    v = '0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 11) == 0) v[c] = ~v[c];
      end
      step(v);
    end
    for (int k = 0; k < 20; k++) step('0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
